// File: rtl/lock_pkg.sv
// Shared key-path definitions for the keypad conditioner and the lock FSM it feeds.
package lock_pkg;

    localparam int unsigned NUM_KEYS   = 5;
    localparam int unsigned KEY_CODE_W = 3;

    localparam logic [KEY_CODE_W-1:0] KEY_NONE = 3'd0;
    localparam logic [KEY_CODE_W-1:0] KEY_D1   = 3'd1;
    localparam logic [KEY_CODE_W-1:0] KEY_D2   = 3'd2;
    localparam logic [KEY_CODE_W-1:0] KEY_D3   = 3'd3;
    localparam logic [KEY_CODE_W-1:0] KEY_D4   = 3'd4;
    localparam logic [KEY_CODE_W-1:0] KEY_D5   = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_HELD
    } arb_state_e;

    // Number of keys currently down.
    function automatic logic [KEY_CODE_W-1:0] key_count(input logic [NUM_KEYS-1:0] keys);
        logic [KEY_CODE_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            n = n + {{(KEY_CODE_W-1){1'b0}}, keys[i]};
        end
        return n;
    endfunction

    // One-hot key vector to key code (bit0 -> KEY_D1); zero maps to KEY_NONE.
    function automatic logic [KEY_CODE_W-1:0] key_to_code(input logic [NUM_KEYS-1:0] keys);
        logic [KEY_CODE_W-1:0] code;
        code = KEY_NONE;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (keys[i]) begin
                code = KEY_CODE_W'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser followed by a stable-count debouncer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Accept a new level only after it has differed from db for DEBOUNCE_CYCLES samples.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign level = db_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Five-button conditioner: debounce, rising-edge detect and a one-key-at-a-time arbiter
// producing registered single-cycle key strobes for the lock FSM.
module keypad_conditioner
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   btn_raw,
    output logic [NUM_KEYS-1:0]   key_pulse,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_err,
    output logic                  key_busy
);

    logic [NUM_KEYS-1:0] db;
    logic [NUM_KEYS-1:0] db_q, db_qq;
    logic [NUM_KEYS-1:0] rise;

    arb_state_e            state_q, state_d;
    logic [NUM_KEYS-1:0]   pulse_q, pulse_d;
    logic                  valid_q, valid_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[g]),
            .level(db[g])
        );
    end

    // Two-stage delay of the debounced levels; the extra stage keeps the arbiter's level
    // view aligned with its edge view and fixes latency at DEBOUNCE_CYCLES+3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q  <= '0;
            db_qq <= '0;
        end else begin
            db_q  <= db;
            db_qq <= db_q;
        end
    end

    assign rise = db_q & ~db_qq;

    // Arbiter next state and next outputs.
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        valid_d = 1'b0;
        code_d  = KEY_NONE;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    state_d = ST_HELD;
                    if (key_count(db_q) == KEY_CODE_W'(1)) begin
                        pulse_d = rise;
                        valid_d = 1'b1;
                        code_d  = key_to_code(rise);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (db_q == '0) begin
                    state_d = ST_IDLE;
                end else if (|rise) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_HELD);
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            valid_q <= 1'b0;
            code_q  <= KEY_NONE;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign key_pulse = pulse_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_err   = err_q;
    assign key_busy  = busy_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner with DEBOUNCE_CYCLES=4 (latency 7).
module tb_keypad_conditioner;

    localparam int unsigned DC  = 4;
    localparam int          LAT = 7;

    logic       clk;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] key_pulse;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_err;
    logic       key_busy;

    int total;
    int bad;
    int cyc = 0;

    // Monitor statistics (cumulative, written only by the monitor).
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         viol_cnt = 0;
    int         last_valid_cyc = -1;
    int         busy_fall_cyc = -1;
    logic [4:0] last_pulse = '0;
    logic [2:0] last_code = '0;
    logic       prev_busy = 1'b0;
    int         code_log[$];

    keypad_conditioner #(
        .DEBOUNCE_CYCLES(DC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .key_pulse(key_pulse),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_err  (key_err),
        .key_busy (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and output invariants on the falling edge.
    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            last_pulse     <= key_pulse;
            last_code      <= key_code;
            code_log.push_back(int'(key_code));
        end
        if (key_err) err_cnt <= err_cnt + 1;
        if (prev_busy && !key_busy) busy_fall_cyc <= cyc;
        prev_busy <= key_busy;
        if ((key_valid != (key_pulse != 5'b0)) || (key_valid && key_err) ||
            (key_err && key_pulse != 5'b0) || (!key_valid && key_code != 3'd0) ||
            (key_valid && !$onehot(key_pulse)) ||
            (key_valid && (key_code == 3'd0 || key_code > 3'd5)) ||
            (key_valid && key_code >= 3'd1 && key_code <= 3'd5 &&
             key_pulse != (5'b00001 << (key_code - 3'd1))))
            viol_cnt <= viol_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pulse"}, int'(key_pulse), 0);
        check_eq({tag, "_valid"}, int'(key_valid), 0);
        check_eq({tag, "_code"},  int'(key_code), 0);
        check_eq({tag, "_err"},   int'(key_err), 0);
        check_eq({tag, "_busy"},  int'(key_busy), 0);
    endtask

    initial begin
        int s, r, v0, e0, n0;
        int exp_codes[3];
        logic [4:0] seq_btn[3];
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        btn_raw = '0;
        cycles(3);
        check_quiet("reset");
        reset = 1'b1;
        cycles(3);

        // 1: single press of d2, held, then released.
        v0 = valid_cnt; e0 = err_cnt;
        btn_raw = 5'b00010; s = cyc + 1;
        cycles(20);
        check_eq("t1_nvalid", valid_cnt, v0 + 1);
        check_eq("t1_latency", last_valid_cyc, s + LAT);
        check_eq("t1_pulse", int'(last_pulse), 2);
        check_eq("t1_code", int'(last_code), 2);
        check_eq("t1_noerr", err_cnt, e0);
        check_eq("t1_busy_held", int'(key_busy), 1);
        btn_raw = '0; r = cyc + 1;
        cycles(12);
        check_eq("t1_busy_fall", busy_fall_cyc, r + LAT);
        check_eq("t1_idle", int'(key_busy), 0);

        // 2: bouncing d3 settles to one strobe; a 3-cycle pulse is rejected.
        v0 = valid_cnt; e0 = err_cnt;
        btn_raw = 5'b00100; cycles(1);
        btn_raw = 5'b00000; cycles(1);
        btn_raw = 5'b00100; cycles(1);
        btn_raw = 5'b00000; cycles(1);
        btn_raw = 5'b00100; s = cyc + 1;
        cycles(20);
        check_eq("t2_nvalid", valid_cnt, v0 + 1);
        check_eq("t2_latency", last_valid_cyc, s + LAT);
        check_eq("t2_pulse", int'(last_pulse), 4);
        check_eq("t2_code", int'(last_code), 3);
        btn_raw = '0;
        cycles(12);
        v0 = valid_cnt;
        btn_raw = 5'b00100; cycles(3);
        btn_raw = 5'b00000; cycles(15);
        check_eq("t2_short_nvalid", valid_cnt, v0);
        check_eq("t2_noerr", err_cnt, e0);
        check_eq("t2_short_busy", int'(key_busy), 0);

        // 3: d1 and d5 together.
        v0 = valid_cnt; e0 = err_cnt;
        btn_raw = 5'b10001;
        cycles(15);
        check_eq("t3_err", err_cnt, e0 + 1);
        check_eq("t3_nvalid", valid_cnt, v0);
        check_eq("t3_busy", int'(key_busy), 1);
        btn_raw = '0;
        cycles(12);
        check_eq("t3_idle", int'(key_busy), 0);
        check_eq("t3_err_once", err_cnt, e0 + 1);

        // 4: d1 accepted, d4 added while held, then d4 alone.
        v0 = valid_cnt; e0 = err_cnt;
        btn_raw = 5'b00001;
        cycles(15);
        check_eq("t4_d1_nvalid", valid_cnt, v0 + 1);
        check_eq("t4_d1_code", int'(last_code), 1);
        btn_raw = 5'b01001;
        cycles(15);
        check_eq("t4_err", err_cnt, e0 + 1);
        check_eq("t4_no_second", valid_cnt, v0 + 1);
        check_eq("t4_busy", int'(key_busy), 1);
        btn_raw = '0;
        cycles(12);
        check_eq("t4_idle", int'(key_busy), 0);
        btn_raw = 5'b01000;
        cycles(15);
        check_eq("t4_d4_nvalid", valid_cnt, v0 + 2);
        check_eq("t4_d4_code", int'(last_code), 4);
        btn_raw = '0;
        cycles(12);

        // 5: reset while d5 is mid-debounce (counter at 2).
        v0 = valid_cnt;
        btn_raw = 5'b10000;
        cycles(4);
        reset = 1'b0;
        cycles(3);
        check_quiet("t5_in_reset");
        reset = 1'b1; s = cyc + 1;
        cycles(15);
        check_eq("t5_nvalid", valid_cnt, v0 + 1);
        check_eq("t5_latency", last_valid_cyc, s + LAT);
        check_eq("t5_code", int'(last_code), 5);
        btn_raw = '0;
        cycles(12);

        // 6: combination-style sequence d2, d3, d1.
        e0 = err_cnt; n0 = code_log.size();
        seq_btn   = '{5'b00010, 5'b00100, 5'b00001};
        exp_codes = '{2, 3, 1};
        for (int i = 0; i < 3; i++) begin
            btn_raw = seq_btn[i]; cycles(15);
            btn_raw = '0;         cycles(12);
        end
        check_eq("t6_count", code_log.size() - n0, 3);
        for (int i = 0; i < 3; i++) begin
            if (n0 + i < code_log.size())
                check_eq($sformatf("t6_code%0d", i), code_log[n0 + i], exp_codes[i]);
            else
                check_eq($sformatf("t6_code%0d", i), -1, exp_codes[i]);
        end
        check_eq("t6_noerr", err_cnt, e0);

        check_eq("invariants", viol_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
